// File: rtl/execute2memory.sv
// Execute-to-memory pipeline register: carries execute results forward, inserts
// bubbles on execute stalls while preserving multi-cycle MADD/MSUB progress.
module execute2memory #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_execute,
   input  logic                   stall_memory,
   input  logic                   flush,
   input  logic [4:0]             dest_addr,
   input  logic                   write_or_not,
   input  logic [31:0]            wdata,
   input  logic                   execute_HILO_enabler,
   input  logic [31:0]            execute_HILO_HI,
   input  logic [31:0]            execute_HILO_LO,
   input  logic [63:0]            hilo_temp_input,
   input  logic [1:0]             cnt_input,
   output logic [4:0]             memory_dest_addr,
   output logic                   memory_write_or_not,
   output logic [31:0]            memory_wdata,
   output logic                   memory_HILO_enabler,
   output logic [31:0]            memory_HILO_HI,
   output logic [31:0]            memory_HILO_LO,
   output logic [63:0]            hilo_temp_output,
   output logic [1:0]             cnt_output,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [4:0]             dest_addr_q,    dest_addr_d;
   logic                   write_q,        write_d;
   logic [31:0]            wdata_q,        wdata_d;
   logic                   hilo_en_q,      hilo_en_d;
   logic [31:0]            hilo_hi_q,      hilo_hi_d;
   logic [31:0]            hilo_lo_q,      hilo_lo_d;
   logic [63:0]            hilo_temp_q,    hilo_temp_d;
   logic [1:0]             cnt_q,          cnt_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic bubble;
   assign bubble = stall_execute & ~stall_memory;

   always_comb begin
      dest_addr_d    = dest_addr_q;
      write_d        = write_q;
      wdata_d        = wdata_q;
      hilo_en_d      = hilo_en_q;
      hilo_hi_d      = hilo_hi_q;
      hilo_lo_d      = hilo_lo_q;
      hilo_temp_d    = hilo_temp_q;
      cnt_d          = cnt_q;
      stall_cycles_d = stall_cycles_q;
      if (flush) begin
         dest_addr_d = '0;
         write_d     = 1'b0;
         wdata_d     = '0;
         hilo_en_d   = 1'b0;
         hilo_hi_d   = '0;
         hilo_lo_d   = '0;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end else if (bubble) begin
         // Memory sees a bubble, but the partial product keeps accumulating.
         dest_addr_d = '0;
         write_d     = 1'b0;
         wdata_d     = '0;
         hilo_en_d   = 1'b0;
         hilo_hi_d   = '0;
         hilo_lo_d   = '0;
         hilo_temp_d = hilo_temp_input;
         cnt_d       = cnt_input;
         if (!(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_ONE;
      end else if (!stall_execute) begin
         dest_addr_d = dest_addr;
         write_d     = write_or_not;
         wdata_d     = wdata;
         hilo_en_d   = execute_HILO_enabler;
         hilo_hi_d   = execute_HILO_HI;
         hilo_lo_d   = execute_HILO_LO;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dest_addr_q    <= '0;
         write_q        <= 1'b0;
         wdata_q        <= '0;
         hilo_en_q      <= 1'b0;
         hilo_hi_q      <= '0;
         hilo_lo_q      <= '0;
         hilo_temp_q    <= '0;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         dest_addr_q    <= dest_addr_d;
         write_q        <= write_d;
         wdata_q        <= wdata_d;
         hilo_en_q      <= hilo_en_d;
         hilo_hi_q      <= hilo_hi_d;
         hilo_lo_q      <= hilo_lo_d;
         hilo_temp_q    <= hilo_temp_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign memory_dest_addr    = dest_addr_q;
   assign memory_write_or_not = write_q;
   assign memory_wdata        = wdata_q;
   assign memory_HILO_enabler = hilo_en_q;
   assign memory_HILO_HI      = hilo_hi_q;
   assign memory_HILO_LO      = hilo_lo_q;
   assign hilo_temp_output    = hilo_temp_q;
   assign cnt_output          = cnt_q;
   assign stall_cycles        = stall_cycles_q;

endmodule

// File: tb/tb_execute2memory.sv
// Directed + random bench for execute2memory; a 4-bit counter instance shares
// all inputs so stall-counter saturation is observable.
module tb_execute2memory;

   logic        clk;
   logic        rst, stall_execute, stall_memory, flush;
   logic [4:0]  dest_addr;
   logic        write_or_not;
   logic [31:0] wdata;
   logic        execute_HILO_enabler;
   logic [31:0] execute_HILO_HI, execute_HILO_LO;
   logic [63:0] hilo_temp_input;
   logic [1:0]  cnt_input;

   logic [4:0]  memory_dest_addr,    s_dest_addr;
   logic        memory_write_or_not, s_write;
   logic [31:0] memory_wdata,        s_wdata;
   logic        memory_HILO_enabler, s_hen;
   logic [31:0] memory_HILO_HI,      s_hi;
   logic [31:0] memory_HILO_LO,      s_lo;
   logic [63:0] hilo_temp_output,    s_temp;
   logic [1:0]  cnt_output,          s_cnt;
   logic [31:0] stall_cycles;
   logic [3:0]  s_stall_cycles;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [4:0]  dest;
      logic        we;
      logic [31:0] wdata;
      logic        hen;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] temp;
      logic [1:0]  cnt;
      logic [31:0] st32;
      logic [3:0]  st4;
   } exp_t;

   exp_t mdl;
   exp_t sb[$];

   execute2memory dut (
      .clk(clk), .rst(rst), .stall_execute(stall_execute), .stall_memory(stall_memory),
      .flush(flush), .dest_addr(dest_addr), .write_or_not(write_or_not), .wdata(wdata),
      .execute_HILO_enabler(execute_HILO_enabler), .execute_HILO_HI(execute_HILO_HI),
      .execute_HILO_LO(execute_HILO_LO), .hilo_temp_input(hilo_temp_input),
      .cnt_input(cnt_input), .memory_dest_addr(memory_dest_addr),
      .memory_write_or_not(memory_write_or_not), .memory_wdata(memory_wdata),
      .memory_HILO_enabler(memory_HILO_enabler), .memory_HILO_HI(memory_HILO_HI),
      .memory_HILO_LO(memory_HILO_LO), .hilo_temp_output(hilo_temp_output),
      .cnt_output(cnt_output), .stall_cycles(stall_cycles)
   );

   execute2memory #(.STALL_CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .stall_execute(stall_execute), .stall_memory(stall_memory),
      .flush(flush), .dest_addr(dest_addr), .write_or_not(write_or_not), .wdata(wdata),
      .execute_HILO_enabler(execute_HILO_enabler), .execute_HILO_HI(execute_HILO_HI),
      .execute_HILO_LO(execute_HILO_LO), .hilo_temp_input(hilo_temp_input),
      .cnt_input(cnt_input), .memory_dest_addr(s_dest_addr),
      .memory_write_or_not(s_write), .memory_wdata(s_wdata),
      .memory_HILO_enabler(s_hen), .memory_HILO_HI(s_hi),
      .memory_HILO_LO(s_lo), .hilo_temp_output(s_temp),
      .cnt_output(s_cnt), .stall_cycles(s_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour of one clock edge given the currently driven inputs.
   function automatic exp_t model_next(exp_t c);
      exp_t n;
      n = c;
      if (rst) begin
         n = '0;
      end else if (flush) begin
         n.dest = 0; n.we = 0; n.wdata = 0; n.hen = 0; n.hi = 0; n.lo = 0;
         n.temp = 0; n.cnt = 0;
      end else if (stall_execute && !stall_memory) begin
         n.dest = 0; n.we = 0; n.wdata = 0; n.hen = 0; n.hi = 0; n.lo = 0;
         n.temp = hilo_temp_input; n.cnt = cnt_input;
         if (c.st32 != 32'hFFFF_FFFF) n.st32 = c.st32 + 1;
         if (c.st4 != 4'hF) n.st4 = c.st4 + 1;
      end else if (!stall_execute) begin
         n.dest = dest_addr; n.we = write_or_not; n.wdata = wdata;
         n.hen = execute_HILO_enabler; n.hi = execute_HILO_HI; n.lo = execute_HILO_LO;
         n.temp = 0; n.cnt = 0;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".dest"},  64'(memory_dest_addr),    64'(e.dest));
      chk({tag, ".we"},    64'(memory_write_or_not), 64'(e.we));
      chk({tag, ".wdata"}, 64'(memory_wdata),        64'(e.wdata));
      chk({tag, ".hen"},   64'(memory_HILO_enabler), 64'(e.hen));
      chk({tag, ".hi"},    64'(memory_HILO_HI),      64'(e.hi));
      chk({tag, ".lo"},    64'(memory_HILO_LO),      64'(e.lo));
      chk({tag, ".temp"},  hilo_temp_output,         e.temp);
      chk({tag, ".cnt"},   64'(cnt_output),          64'(e.cnt));
      chk({tag, ".st32"},  64'(stall_cycles),        64'(e.st32));
      chk({tag, ".st4"},   64'(s_stall_cycles),      64'(e.st4));
   endtask

   task automatic step(input string tag);
      exp_t e;
      mdl = model_next(mdl);
      sb.push_back(mdl);
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_all(tag, e);
      end
   endtask

   task automatic drive(input logic r, input logic se, input logic sm, input logic fl);
      rst = r; stall_execute = se; stall_memory = sm; flush = fl;
   endtask

   initial begin
      mdl = '0;
      drive(1, 1, 0, 1);
      dest_addr = 5'd9; write_or_not = 1; wdata = 32'hDEAD_BEEF;
      execute_HILO_enabler = 1; execute_HILO_HI = 32'h11; execute_HILO_LO = 32'h22;
      hilo_temp_input = 64'h5; cnt_input = 2'd2;
      #1;
      step("reset");

      drive(0, 0, 0, 0);
      dest_addr = 5'd3; write_or_not = 1; wdata = 32'h1234_5678;
      execute_HILO_enabler = 0; execute_HILO_HI = 0; execute_HILO_LO = 0;
      step("advance");

      drive(0, 1, 0, 0);
      hilo_temp_input = 64'h0000_0001_0000_0002; cnt_input = 2'd1; wdata = 32'hFFFF_FFFF;
      step("bubble");

      drive(0, 0, 0, 0);
      wdata = 32'hA5A5_A5A5; dest_addr = 5'd7;
      step("capture_a5");
      drive(0, 1, 1, 0);
      wdata = 32'h0; dest_addr = 5'd0;
      step("hold1");
      step("hold2");
      step("hold3");

      drive(0, 0, 0, 0);
      execute_HILO_enabler = 1; execute_HILO_HI = 32'hCAFE_0001; execute_HILO_LO = 32'hCAFE_0002;
      step("hilo_adv");
      drive(0, 1, 0, 0);
      step("hilo_bubble");

      drive(0, 0, 0, 1);
      execute_HILO_enabler = 1; execute_HILO_HI = 32'h1; wdata = 32'h55;
      step("flush");

      drive(0, 0, 1, 0);
      dest_addr = 5'd31; wdata = 32'h0BAD_F00D;
      step("adv_mem_stall");

      drive(1, 0, 0, 0);
      step("reset2");
      drive(0, 1, 0, 0);
      cnt_input = 2'd1; hilo_temp_input = 64'hABCD;
      for (int i = 0; i < 7; i++) step("bubble7");
      rst = 1; #2; rst = 0; #1;
      check_all("rst_no_edge", mdl);
      drive(1, 1, 0, 0);
      step("reset_mid_acc");

      drive(0, 1, 0, 0);
      for (int i = 0; i < 20; i++) step("sat");
      drive(0, 1, 1, 0);
      step("sat_hold");
      drive(0, 1, 0, 0);
      step("sat_more");

      for (int i = 0; i < 60; i++) begin
         rst = ($urandom_range(0, 15) == 0);
         flush = ($urandom_range(0, 7) == 0);
         stall_execute = $urandom_range(0, 1);
         stall_memory = $urandom_range(0, 1);
         dest_addr = 5'($urandom); write_or_not = 1'($urandom); wdata = $urandom;
         execute_HILO_enabler = 1'($urandom);
         execute_HILO_HI = $urandom; execute_HILO_LO = $urandom;
         hilo_temp_input = {$urandom, $urandom}; cnt_input = 2'($urandom);
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
